// File: rtl/timer_cfg_sequencer_if.sv
// Command port and APB bus for timer_cfg_sequencer.
// master: sequencer side (accepts commands, drives the APB request).
// slave : host + timer side (issues commands, answers APB transfers).
interface timer_cfg_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_tdr;
    logic       cmd_down;
    logic [1:0] cmd_cks;

    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        input  cmd_valid, cmd_tdr, cmd_down, cmd_cks, prdata, pready, pslverr,
        output cmd_ready, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_tdr, cmd_down, cmd_cks, prdata, pready, pslverr,
        input  cmd_ready, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/timer_cfg_sequencer.sv
// timer_cfg_sequencer: APB master that loads, starts and polls the 8-bit timer
// for one host command, then clears the status and reports done (or err).
//
// Optional feature macro: TIMER_SEQ_ABORT_EN
//   defined   -> abort_i input; abort in GAP/R_TSR stops the timer via ERR,
//                taking effect only at a transfer boundary.
//   undefined -> no abort port; a poll loop ends only on flag, timeout or pslverr.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready=1
// W_TDR   | write TDR <= cmd_tdr
// W_LOAD  | write TCR with load bit set
// W_START | write TCR with enable bit set
// GAP     | idle cycles between TSR reads
// R_TSR   | read TSR and test the flag for the selected direction
// W_CLR   | write TSR <= 0
// DONE    | done pulse
// ERR     | write TCR <= 0 to stop the timer, err pulse on completion
//
// Every transfer state walks SETUP -> ACCESS (until pready) -> TAIL; the TAIL
// cycle keeps psel low so transfers are never back-to-back, and it is where the
// state decision is taken from the captured pslverr/flag.
module timer_cfg_sequencer #(
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned POLL_MAX = 1024
) (
    input  logic                         pclk_i,
    input  logic                         presetn_i,
`ifdef TIMER_SEQ_ABORT_EN
    input  logic                         abort_i,
`endif
    timer_cfg_sequencer_if.master        bus,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_TDR,
        S_W_LOAD,
        S_W_START,
        S_GAP,
        S_R_TSR,
        S_W_CLR,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_ACCESS,
        PH_TAIL
    } phase_t;

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

    // First gap after start counts POLL_GAP cycles; between reads the TAIL
    // cycle of the previous read already counts as one idle cycle.
    localparam logic [15:0] GAP_FIRST = 16'(POLL_GAP - 1);
    localparam logic [15:0] GAP_NEXT  = (POLL_GAP > 1) ? 16'(POLL_GAP - 2) : 16'd0;
    localparam logic [10:0] POLL_LIM  = (POLL_MAX > 2047) ? 11'h7FF : 11'(POLL_MAX);
    localparam bit          POLL_TMO  = (POLL_MAX != 0);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  tdr_q, tdr_d;
    logic        down_q, down_d;
    logic [1:0]  cks_q, cks_d;
    logic [10:0] polls_q, polls_d;
    logic [15:0] gap_q, gap_d;
    logic        flag_q, flag_d;
    logic        slverr_q, slverr_d;

    logic        is_xfer;
    logic        xfer_end;
    logic        xfer_wr;
    logic [7:0]  xfer_addr;
    logic [7:0]  xfer_wdata;
    logic        drive;
    logic [7:0]  tcr_cfg;
    logic [7:0]  flag_mask;
    logic        timeout;
    logic        abort_gap;
    logic        abort_rd;

`ifdef TIMER_SEQ_ABORT_EN
    logic abort_q, abort_d;

    // An abort raised during a TSR read is remembered until that read ends.
    always_comb begin
        abort_d = abort_q;
        if (state_q == S_IDLE) begin
            abort_d = 1'b0;
        end else if (state_q == S_R_TSR && abort_i) begin
            abort_d = 1'b1;
        end
    end

    // Abort latch register.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_d;
        end
    end

    assign abort_gap = abort_i;
    assign abort_rd  = abort_q | abort_i;
`else
    assign abort_gap = 1'b0;
    assign abort_rd  = 1'b0;
`endif

    assign tcr_cfg   = {2'b00, down_q, 1'b0, 2'b00, cks_q};
    assign flag_mask = {6'b000000, down_q, ~down_q};
    assign timeout   = POLL_TMO && (polls_q >= POLL_LIM);

    // Next-state logic, APB request and status outputs.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tdr_d      = tdr_q;
        down_d     = down_q;
        cks_d      = cks_q;
        polls_d    = polls_q;
        gap_d      = gap_q;
        flag_d     = flag_q;
        slverr_d   = slverr_q;

        bus.cmd_ready = 1'b0;
        bus.psel      = 1'b0;
        bus.penable   = 1'b0;
        bus.pwrite    = 1'b0;
        bus.paddr     = 8'h00;
        bus.pwdata    = 8'h00;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        err_o         = 1'b0;

        is_xfer    = 1'b1;
        xfer_end   = 1'b0;
        xfer_wr    = 1'b1;
        xfer_addr  = ADDR_TDR;
        xfer_wdata = 8'h00;
        drive      = 1'b0;

        case (state_q)
            S_W_TDR:   begin xfer_addr = ADDR_TDR; xfer_wdata = tdr_q;            end
            S_W_LOAD:  begin xfer_addr = ADDR_TCR; xfer_wdata = tcr_cfg | 8'h80;  end
            S_W_START: begin xfer_addr = ADDR_TCR; xfer_wdata = tcr_cfg | 8'h10;  end
            S_R_TSR:   begin xfer_addr = ADDR_TSR; xfer_wr = 1'b0;               end
            S_W_CLR:   begin xfer_addr = ADDR_TSR; xfer_wdata = 8'h00;            end
            S_ERR:     begin xfer_addr = ADDR_TCR; xfer_wdata = 8'h00;            end
            default:   is_xfer = 1'b0;
        endcase

        if (is_xfer) begin
            case (phase_q)
                PH_SETUP: begin
                    drive   = 1'b1;
                    phase_d = PH_ACCESS;
                end
                PH_ACCESS: begin
                    drive       = 1'b1;
                    bus.penable = 1'b1;
                    if (bus.pready) begin
                        phase_d  = PH_TAIL;
                        slverr_d = bus.pslverr;
                        flag_d   = |(bus.prdata & flag_mask);
                        if (state_q == S_R_TSR && polls_q != 11'h7FF) begin
                            polls_d = polls_q + 11'd1;
                        end
                    end
                end
                default: xfer_end = 1'b1;
            endcase
        end

        if (drive) begin
            bus.psel   = 1'b1;
            bus.pwrite = xfer_wr;
            bus.paddr  = xfer_addr;
            bus.pwdata = xfer_wr ? xfer_wdata : 8'h00;
        end

        case (state_q)
            S_IDLE: begin
                busy_o        = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    tdr_d    = bus.cmd_tdr;
                    down_d   = bus.cmd_down;
                    cks_d    = bus.cmd_cks;
                    polls_d  = 11'd0;
                    flag_d   = 1'b0;
                    slverr_d = 1'b0;
                    phase_d  = PH_SETUP;
                    state_d  = S_W_TDR;
                end
            end
            S_W_TDR, S_W_LOAD, S_W_START, S_W_CLR: begin
                if (xfer_end) begin
                    phase_d = PH_SETUP;
                    if (slverr_q) begin
                        state_d = S_ERR;
                    end else if (state_q == S_W_TDR) begin
                        state_d = S_W_LOAD;
                    end else if (state_q == S_W_LOAD) begin
                        state_d = S_W_START;
                    end else if (state_q == S_W_START) begin
                        state_d = S_GAP;
                        gap_d   = GAP_FIRST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (abort_gap) begin
                    state_d = S_ERR;
                    phase_d = PH_SETUP;
                end else if (gap_q == 16'd0) begin
                    state_d = S_R_TSR;
                    phase_d = PH_SETUP;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            S_R_TSR: begin
                if (xfer_end) begin
                    phase_d = PH_SETUP;
                    if (slverr_q || abort_rd) begin
                        state_d = S_ERR;
                    end else if (flag_q) begin
                        state_d = S_W_CLR;
                    end else if (timeout) begin
                        state_d = S_ERR;
                    end else if (POLL_GAP > 1) begin
                        state_d = S_GAP;
                        gap_d   = GAP_NEXT;
                    end else begin
                        state_d = S_R_TSR;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                // A failing stop write still ends here: one err pulse per command.
                if (xfer_end) begin
                    err_o   = 1'b1;
                    phase_d = PH_SETUP;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = PH_SETUP;
            end
        endcase
    end

    // State, captured command and counters.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SETUP;
            tdr_q    <= 8'h00;
            down_q   <= 1'b0;
            cks_q    <= 2'b00;
            polls_q  <= 11'd0;
            gap_q    <= 16'd0;
            flag_q   <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tdr_q    <= tdr_d;
            down_q   <= down_d;
            cks_q    <= cks_d;
            polls_q  <= polls_d;
            gap_q    <= gap_d;
            flag_q   <= flag_d;
            slverr_q <= slverr_d;
        end
    end

endmodule
